// File: rtl/move_event_gen_if.sv
// rtl/move_event_gen_if.sv - move command valid/ready handshake bundle
interface move_event_gen_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_event_gen.sv
// rtl/move_event_gen.sv - debounced joystick direction to one-shot move commands
module move_event_gen #(
  parameter logic [23:0] STABLE_CYCLES = 24'd1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             dir_in,
  move_event_gen_if.master       m_move,
  output logic [15:0]            move_count,
  output logic                   armed
);

  localparam logic [2:0] DIR_NEUTRAL = 3'b100;

  typedef enum logic [1:0] {ST_ARMED, ST_PEND, ST_WAIT_REL} state_t;

  logic [2:0]  w_dir_in_map;
  logic [2:0]  r_dir_q;
  logic [2:0]  r_cand;
  logic [23:0] r_cnt;
  logic [2:0]  r_dir_stable;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_move_valid;
  logic        w_move_valid_nxt;
  logic [1:0]  r_move_dir;
  logic [1:0]  w_move_dir_nxt;
  logic [15:0] r_move_count;
  logic [15:0] w_move_count_nxt;

  // Codes 101-111 collapse to neutral before anything else sees them
  assign w_dir_in_map = dir_in[2] ? DIR_NEUTRAL : dir_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir_q      <= DIR_NEUTRAL;
      r_cand       <= DIR_NEUTRAL;
      r_cnt        <= 24'd0;
      r_dir_stable <= DIR_NEUTRAL;
    end else begin
      r_dir_q <= w_dir_in_map;
      if (r_dir_q != r_cand) begin
        r_cand <= r_dir_q;
        r_cnt  <= 24'd0;
      end else if (r_cnt < STABLE_CYCLES - 24'd1) begin
        r_cnt <= r_cnt + 24'd1;
      end else begin
        r_dir_stable <= r_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ARMED;
      r_move_valid <= 1'b0;
      r_move_dir   <= 2'b00;
      r_move_count <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_move_valid <= w_move_valid_nxt;
      r_move_dir   <= w_move_dir_nxt;
      r_move_count <= w_move_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_move_valid_nxt = r_move_valid;
    w_move_dir_nxt   = r_move_dir;
    w_move_count_nxt = r_move_count;
    case (r_state)
      ST_ARMED: begin
        if (!r_dir_stable[2]) begin
          w_move_valid_nxt = 1'b1;
          w_move_dir_nxt   = r_dir_stable[1:0];
          w_state_nxt      = ST_PEND;
        end
      end
      ST_PEND: begin
        // Direction changes are ignored here; only the handshake moves on
        if (r_move_valid && m_move.move_ready) begin
          w_move_valid_nxt = 1'b0;
          w_move_count_nxt = r_move_count + 16'd1;
          w_state_nxt      = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (r_dir_stable == DIR_NEUTRAL) begin
          w_state_nxt = ST_ARMED;
        end
      end
      default: begin
        w_state_nxt = ST_ARMED;
      end
    endcase
  end

  assign m_move.move_valid = r_move_valid;
  assign m_move.move_dir   = r_move_dir;
  assign move_count        = r_move_count;
  assign armed             = (r_state == ST_ARMED);

endmodule

// File: tb/tb_move_event_gen.sv
// tb/tb_move_event_gen.sv - directed self-checking bench for move_event_gen
module tb_move_event_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  dir_in = 3'b100;
  logic [15:0] move_count;
  logic        armed;
  int          n_vec = 0;
  int          n_miss = 0;
  int          e;
  int          h;
  int          a_lo;

  move_event_gen_if u_if ();

  move_event_gen #(.STABLE_CYCLES(24'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dir_in     (dir_in),
    .m_move     (u_if),
    .move_count (move_count),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int edges);
    int i;
    edges = -1;
    i = 0;
    while (edges < 0 && i < max) begin
      step();
      i++;
      if (u_if.move_valid) edges = i;
    end
  endtask

  task automatic run_watch(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (u_if.move_valid) hi++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dir_in = 3'b100;
    u_if.move_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    u_if.move_ready = 1'b0;
    step();
    #2;
    chk("rst_valid", {31'd0, u_if.move_valid}, 32'd0);
    chk("rst_dir", {30'd0, u_if.move_dir}, 32'd0);
    chk("rst_count", {16'd0, move_count}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd1);
    rst = 1'b1;
    h = 0;
    a_lo = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (u_if.move_valid) h++;
      if (!armed) a_lo++;
    end
    chk("idle_valid", h, 0);
    chk("idle_armed_low", a_lo, 0);

    // single push, ready held high
    u_if.move_ready = 1'b1;
    dir_in = 3'b001;
    wait_valid(20, e);
    chk("push_latency", e, 7);
    chk("push_dir", {30'd0, u_if.move_dir}, 32'd1);
    step();
    chk("push_one_cycle", {31'd0, u_if.move_valid}, 32'd0);
    chk("push_count", {16'd0, move_count}, 32'd1);
    run_watch(100, h);
    chk("hold_no_refire", h, 0);
    chk("hold_count", {16'd0, move_count}, 32'd1);

    // glitch shorter than the stability window
    do_reset();
    u_if.move_ready = 1'b1;
    dir_in = 3'b000;
    step(); step(); step();
    dir_in = 3'b100;
    run_watch(30, h);
    chk("glitch_valid", h, 0);
    chk("glitch_count", {16'd0, move_count}, 32'd0);

    // backpressure while the stick moves on
    do_reset();
    dir_in = 3'b010;
    wait_valid(20, e);
    chk("bp_latency", e, 7);
    chk("bp_dir", {30'd0, u_if.move_dir}, 32'd2);
    dir_in = 3'b011;
    run_watch(20, h);
    chk("bp_held", h, 20);
    chk("bp_dir_held", {30'd0, u_if.move_dir}, 32'd2);
    chk("bp_not_armed", {31'd0, armed}, 32'd0);
    u_if.move_ready = 1'b1;
    step();
    u_if.move_ready = 1'b0;
    chk("bp_xfer_valid", {31'd0, u_if.move_valid}, 32'd0);
    chk("bp_xfer_count", {16'd0, move_count}, 32'd1);
    u_if.move_ready = 1'b1;
    run_watch(30, h);
    chk("bp_no_left", h, 0);
    dir_in = 3'b100;
    run_watch(10, h);
    chk("bp_rearmed", {31'd0, armed}, 32'd1);
    dir_in = 3'b011;
    wait_valid(20, e);
    chk("bp_left_latency", e, 7);
    chk("bp_left_dir", {30'd0, u_if.move_dir}, 32'd3);
    step();
    chk("bp_left_count", {16'd0, move_count}, 32'd2);

    // up, neutral, left, then left again without a full neutral
    do_reset();
    u_if.move_ready = 1'b1;
    dir_in = 3'b000;
    wait_valid(20, e);
    chk("re_up_dir", {30'd0, u_if.move_dir}, 32'd0);
    chk("re_up_valid", {31'd0, u_if.move_valid}, 32'd1);
    step();
    dir_in = 3'b100;
    run_watch(10, h);
    dir_in = 3'b011;
    wait_valid(20, e);
    chk("re_left_latency", e, 7);
    chk("re_left_dir", {30'd0, u_if.move_dir}, 32'd3);
    step();
    chk("re_count", {16'd0, move_count}, 32'd2);
    dir_in = 3'b100;
    step(); step(); step();
    dir_in = 3'b011;
    run_watch(30, h);
    chk("re_short_neutral", h, 0);
    chk("re_count_final", {16'd0, move_count}, 32'd2);

    // reset with a move pending
    do_reset();
    u_if.move_ready = 1'b1;
    dir_in = 3'b001;
    wait_valid(20, e);
    step();
    chk("mp_first_count", {16'd0, move_count}, 32'd1);
    dir_in = 3'b100;
    run_watch(10, h);
    u_if.move_ready = 1'b0;
    dir_in = 3'b010;
    wait_valid(20, e);
    chk("mp_pending", {31'd0, u_if.move_valid}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mp_async_valid", {31'd0, u_if.move_valid}, 32'd0);
    chk("mp_async_count", {16'd0, move_count}, 32'd0);
    chk("mp_async_armed", {31'd0, armed}, 32'd1);
    chk("mp_async_dir", {30'd0, u_if.move_dir}, 32'd0);
    dir_in = 3'b100;
    step();
    rst = 1'b1;
    step();

    // counter wrap
    @(negedge clk);
    force dut.r_move_count = 16'hFFFF;
    step();
    release dut.r_move_count;
    step();
    chk("wrap_preset", {16'd0, move_count}, 32'h0000FFFF);
    u_if.move_ready = 1'b1;
    dir_in = 3'b000;
    wait_valid(20, e);
    chk("wrap_latency", e, 7);
    step();
    chk("wrap_count", {16'd0, move_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
